// File: rtl/fsqrt_pkg.sv
// fsqrt_pkg: shared types and constants for the square-root refinement unit.
// Build option: FSQRT_ROUND_EN adds a round-to-nearest ROUND state.
package fsqrt_pkg;

  typedef enum logic [2:0] {IDLE, INIT, CORR, ITER, ROUND, DONE} state_t;

  localparam int MANT_BITS = 23;
  localparam int SEED_BITS = 6;
  localparam int ITER_CNT  = 17;
  localparam int R_W       = 50;
  localparam int Q_W       = 24;
  localparam logic [31:0] QNAN = 32'h7FC00000;

  // Radicand scaled so that the root lands as sqrt*2^23 with the hidden bit at [23].
  // An even biased exponent means an odd unbiased one, so the mantissa is doubled.
  function automatic logic [47:0] radicand(input logic e0, input logic [MANT_BITS-1:0] m);
    return e0 ? {2'b01, m, 23'b0} : {1'b1, m, 24'b0};
  endfunction

endpackage

// File: rtl/fsqrt_refine_if.sv
// fsqrt_refine_if: request/result bundle between seed path, refiner and result mux.
interface fsqrt_refine_if;
  logic [31:0] x;
  logic [31:0] seed;
  logic        ready;
  logic        busy;
  logic [31:0] y;
  logic        valid;

  modport master (output x, seed, ready, input  busy, y, valid);
  modport slave  (input  x, seed, ready, output busy, y, valid);
endinterface

// File: rtl/fsqrt_step.sv
// fsqrt_step: one restoring digit-recurrence trial for root bit k.
module fsqrt_step
  import fsqrt_pkg::*;
(
  input  logic signed [R_W-1:0] r,
  input  logic        [Q_W-1:0] q,
  input  logic        [4:0]     k,
  output logic signed [R_W-1:0] r_next,
  output logic        [Q_W-1:0] q_next
);
  logic signed [R_W-1:0] t;

  // (Q + 2^k)^2 - Q^2 = Q*2^(k+1) + 2^(2k); bits below k of Q are still zero.
  always_comb begin
    t      = ({{(R_W-Q_W){1'b0}}, q} << (k + 5'd1)) + ({{(R_W-1){1'b0}}, 1'b1} << {k, 1'b0});
    r_next = r;
    q_next = q;
    if (r >= t) begin
      r_next = r - t;
      q_next = q | ({{(Q_W-1){1'b0}}, 1'b1} << k);
    end
  end
endmodule

// File: rtl/fsqrt_refine.sv
// fsqrt_refine: completes a 6-bit sqrt seed to a single-precision root,
// one mantissa bit per cycle. Build option: FSQRT_ROUND_EN (round to nearest).
module fsqrt_refine
  import fsqrt_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  fsqrt_refine_if.slave bus
);
  state_t                state, state_n;
  logic [47:0]           rad_q, rad_n;
  logic [7:0]            sexp_q, sexp_n;
  logic [SEED_BITS-1:0]  smant_q, smant_n;
  logic signed [R_W-1:0] r, r_n, st_r;
  logic [Q_W-1:0]        q, q_n, st_q;
  logic [4:0]            k, k_n;
  logic [31:0]           y_q, y_n;
  logic                  valid_q, valid_n;
  logic [6:0]            q7;
  logic [13:0]           sq;
`ifdef FSQRT_ROUND_EN
  logic [Q_W:0]          q_rnd;
`endif
  logic                  unused_seed;

  assign unused_seed = ^{bus.seed[31], bus.seed[16:0]};
  assign q7          = {1'b1, smant_q};
  assign sq          = q7 * q7;

  fsqrt_step u_step (.r(r), .q(q), .k(k), .r_next(st_r), .q_next(st_q));

  assign bus.y     = y_q;
  assign bus.valid = valid_q;
  assign bus.busy  = (state == INIT) || (state == CORR) || (state == ITER) || (state == ROUND);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rad_q   <= '0;
      sexp_q  <= '0;
      smant_q <= '0;
      r       <= '0;
      q       <= '0;
      k       <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      rad_q   <= rad_n;
      sexp_q  <= sexp_n;
      smant_q <= smant_n;
      r       <= r_n;
      q       <= q_n;
      k       <= k_n;
      y_q     <= y_n;
      valid_q <= valid_n;
    end
  end

  // Next-state and datapath: specials finish on acceptance, otherwise
  // seed -> correct overestimate -> 17 trials -> (round) -> publish.
  always_comb begin
    state_n = state;
    rad_n   = rad_q;
    sexp_n  = sexp_q;
    smant_n = smant_q;
    r_n     = r;
    q_n     = q;
    k_n     = k;
    y_n     = y_q;
    valid_n = 1'b0;
`ifdef FSQRT_ROUND_EN
    q_rnd   = {1'b0, q};
`endif
    case (state)
      IDLE: if (bus.ready) begin
        if (bus.x[30:23] == 8'd0) begin
          y_n = {bus.x[31], 31'b0};  valid_n = 1'b1; state_n = DONE;
        end else if (bus.x[30:23] == 8'hFF) begin
          y_n = bus.x;               valid_n = 1'b1; state_n = DONE;
        end else if (bus.x[31]) begin
          y_n = QNAN;                valid_n = 1'b1; state_n = DONE;
        end else begin
          rad_n   = radicand(bus.x[23], bus.x[22:0]);
          sexp_n  = bus.seed[30:23];
          smant_n = bus.seed[22:17];
          state_n = INIT;
        end
      end
      INIT: begin
        q_n     = {q7, 17'b0};
        r_n     = $signed({2'b00, rad_q}) - $signed({2'b00, sq, 34'b0});
        state_n = CORR;
      end
      CORR: begin
        if (r[R_W-1]) begin
          // Step the seed down one seed ulp: r += 2*Q*2^17 - 2^34.
          r_n = r + $signed({8'b0, q, 18'b0}) - $signed(50'h4_0000_0000);
          q_n = q - 24'h02_0000;
        end else begin
          k_n     = 5'(ITER_CNT - 1);
          state_n = ITER;
        end
      end
      ITER: begin
        r_n = st_r;
        q_n = st_q;
        k_n = k - 5'd1;
        if (k == 5'd0) begin
`ifdef FSQRT_ROUND_EN
          state_n = ROUND;
`else
          y_n     = {1'b0, sexp_q, st_q[MANT_BITS-1:0]};
          valid_n = 1'b1;
          state_n = DONE;
`endif
        end
      end
`ifdef FSQRT_ROUND_EN
      ROUND: begin
        // r > Q means sqrt exceeds Q + 1/2; exact ties cannot occur.
        q_rnd   = {1'b0, q} + {{Q_W{1'b0}}, (r > $signed({{(R_W-Q_W){1'b0}}, q}))};
        y_n     = q_rnd[Q_W] ? {1'b0, sexp_q + 8'd1, 23'b0}
                             : {1'b0, sexp_q, q_rnd[MANT_BITS-1:0]};
        valid_n = 1'b1;
        state_n = DONE;
      end
`endif
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule
